// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunked multi-cycle adder.
// Holds the FSM state encoding and index-width helpers.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/ripple_adder_n.sv
// N-bit combinational ripple-carry adder.
// Also exposes the carry into the top bit for signed overflow.
module ripple_adder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] y,
  output logic         c_out,
  output logic         c_msb_in
);

  logic cy;

  always_comb begin
    cy       = c_in;
    c_msb_in = c_in;
    y        = '0;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) c_msb_in = cy;
      y[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/sub: CHUNK bits per clock, carry kept in a register.
// Valid/ready on both sides; one operation in flight at a time.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = max1(clog2(NCHUNK));
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IW-1:0]    idx;
  int               off;
  logic [CHUNK-1:0] sum;
  logic             cc;
  logic             cm;

  assign off = CHUNK * int'(idx);

  ripple_adder_n #(.N(CHUNK)) u_add (
    .a        (a_q[off +: CHUNK]),
    .b        (b_q[off +: CHUNK]),
    .c_in     (carry),
    .y        (sum),
    .c_out    (cc),
    .c_msb_in (cm)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      y     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub | c_in;
            y     <= '0;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          y[off +: CHUNK] <= sum;
          carry           <= cc;
          if (idx == LAST) begin
            c_out <= cc;
            ovf   <= cm ^ cc;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_hs_excl: assert property (
    @(posedge clk) disable iff (!rst_n) !(out_valid && in_ready)
  );

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per clock, with a ripple carry held in a register between chunks.
- Generalises the team's fixed 4-bit ripple adder in width and slice size, and adds subtract mode, signed-overflow flag and valid/ready handshakes on both sides.
- Used where area matters more than latency: datapath accumulators and address arithmetic in the multi-cycle core.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH
NCHUNK, WIDTH/CHUNK, derived (localparam), cycles per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands/command valid
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry in (add mode only)
sub  input  1  1: y = a - b; 0: y = a + b + c_in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  sum/difference
c_out  output  1  carry out of MSB (sub mode: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any state): state=IDLE, y=0, c_out=0, ovf=0, out_valid=0, chunk index=0, carry register=0. in_ready=1 (decoded from IDLE). An operation in flight is discarded; no partial result is ever presented.
- FSM IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: register a, b (b inverted if sub=1), sub. Carry register = sub ? 1 : c_in. Clear y. Index=0. Go to RUN.
- FSM RUN:
  - in_ready=0.
  - Each cycle, chunk k=index: y[k*CHUNK +: CHUNK] <= a_k + b_k + carry; carry <= chunk carry-out.
  - On the last chunk (k=NCHUNK-1): c_out <= chunk carry-out; ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. Go to DONE.
  - Otherwise index <= index+1.
- FSM DONE:
  - out_valid=1, in_ready=0.
  - y, c_out and ovf are held stable while out_ready=0.
  - On out_ready=1, go to IDLE the next cycle. out_valid drops; y, c_out and ovf keep their values until the next accept.
- Latency: accept at edge E; out_valid=1 after edge E+NCHUNK. Minimum initiation interval is NCHUNK+2 cycles; no overlap of operations.
- in_valid and operand changes are ignored outside IDLE. c_in is ignored when sub=1.
- Width rules:
  - Result is modulo 2^WIDTH.
  - ovf is meaningful for signed interpretation only; c_out for unsigned.
- CHUNK=WIDTH: RUN lasts exactly one cycle.
- CHUNK=1: pure bit-serial operation, WIDTH cycles.
- Assertions: WIDTH%CHUNK==0 checked at elaboration; out_valid and in_ready never both 1.

Decomposition:
- Shared package: FSM state encoding (IDLE, RUN, DONE as 2-bit constants); function clog2 used for the index width, max(1, clog2(NCHUNK)).
- Sub-module ripple_adder_n:
  - Parameter N. Ports: a[N], b[N], c_in, y[N], c_out, c_msb_in (carry into bit N-1).
  - Combinational chain of full adders, instantiated once with N=CHUNK.
  - c_msb_in drives ovf.

Test Plan:
1. WIDTH=16, CHUNK=4; a=0xFFFF, b=0x0001, c_in=0, sub=0 -> y=0x0000, c_out=1, ovf=0; out_valid rises exactly 4 cycles after accept.
2. a=0x7FFF, b=0x0001, sub=0 -> y=0x8000, c_out=0, ovf=1. Then a=0x8000, b=0x0001, sub=1 -> y=0x7FFF, c_out=1, ovf=1.
3. a=0x0005, b=0x0007, sub=1, c_in=1 (ignored) -> y=0xFFFE, c_out=0, ovf=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and changing a/b -> y/c_out/ovf stable, in_ready=0. Raise out_ready -> IDLE next cycle; new operation accepted and correct.
5. Reset mid-op: assert rst_n=0 asynchronously during RUN at chunk 2 -> outputs 0, out_valid=0, in_ready=1 immediately. Next operation 0x1234+0x1111 -> y=0x2345.
6. Random 1000 operations each for CHUNK=1, 4 and 16 against a behavioural model, with random handshake delays -> all y/c_out/ovf match; latency = WIDTH/CHUNK cycles.
